stream_packet_arbiter: RTL and testbench

STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

---
 rtl/stream_packet_arbiter_if.sv | 52 +++++
 rtl/stream_packet_arbiter.sv | 120 ++++++++++++
 tb/tb_stream_packet_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_packet_arbiter_if.sv
// Stream bundle for stream_packet_arbiter: two AXI-Stream-style sources
// (s0, s1) and one merged output stream (m).
//
// Handshake rule for every stream in this bundle: a beat transfers on a
// rising clock edge where tvalid && tready are both 1. A producer that raises
// tvalid keeps it, tdata and tlast stable until that edge. tready may change
// freely and carries no meaning while tvalid is 0.
//
// Signals:
//   s0_tdata/s0_tvalid/s0_tlast -> s0_tready   source 0 (write-channel mirror)
//   s1_tdata/s1_tvalid/s1_tlast -> s1_tready   source 1 (read-channel mirror)
//   m_tdata/m_tvalid/m_tlast/m_tid <- m_tready merged output, m_tid = source
// Modports:
//   slave  - the arbiter's view (consumes sources, produces m)
//   master - the environment's view (produces sources, consumes m)
interface stream_packet_arbiter_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] s0_tdata;
  logic              s0_tvalid;
  logic              s0_tlast;
  logic              s0_tready;

  logic [DATA_W-1:0] s1_tdata;
  logic              s1_tvalid;
  logic              s1_tlast;
  logic              s1_tready;

  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tid;
  logic              m_tready;

  modport slave (
    input  s0_tdata, s0_tvalid, s0_tlast,
    output s0_tready,
    input  s1_tdata, s1_tvalid, s1_tlast,
    output s1_tready,
    output m_tdata, m_tvalid, m_tlast, m_tid,
    input  m_tready
  );

  modport master (
    output s0_tdata, s0_tvalid, s0_tlast,
    input  s0_tready,
    output s1_tdata, s1_tvalid, s1_tlast,
    input  s1_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tid,
    output m_tready
  );
endinterface

// File: rtl/stream_packet_arbiter.sv
// stream_packet_arbiter: merges two packet streams into one, forwarding whole
// packets with round-robin arbitration between sources on packet boundaries.
//
// Ports:
//   aclk      in   clock, everything on the rising edge
//   aresetn   in   synchronous active-low reset
//   bus       slave modport of stream_packet_arbiter_if (s0, s1, m streams)
//   src_en    in   [1:0] per-source enable, only looked at while IDLE
//   pkt_cnt0  out  [CNT_W-1:0] packets (tlast beats) accepted from source 0
//   pkt_cnt1  out  [CNT_W-1:0] packets (tlast beats) accepted from source 1
//   state_dbg out  [1:0] current FSM state (0 IDLE, 1 GRANT0, 2 GRANT1)
module stream_packet_arbiter #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  stream_packet_arbiter_if.slave  bus,
  input  logic [1:0]              src_en,
  output logic [CNT_W-1:0]        pkt_cnt0,
  output logic [CNT_W-1:0]        pkt_cnt1,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  // Last granted source: 0 = source 0, 1 = source 1.
  logic              rr_q, rr_d;

  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic              m_tid_q;
  logic [CNT_W-1:0]  cnt0_q, cnt1_q;

  logic              req0, req1;
  logic              out_free;
  logic              s0_rdy, s1_rdy;
  logic              acc0, acc1;

  assign req0 = bus.s0_tvalid && src_en[0];
  assign req1 = bus.s1_tvalid && src_en[1];

  // The single output register can take a new beat when it is empty or is
  // being drained this same cycle, giving one beat per cycle in a packet.
  assign out_free = !m_valid_q || bus.m_tready;

  assign acc0 = s0_rdy && bus.s0_tvalid;
  assign acc1 = s1_rdy && bus.s1_tvalid;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    s0_rdy  = 1'b0;
    s1_rdy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the source that was not served last wins.
        if (req0 && (!req1 || rr_q)) begin
          state_d = GRANT0;
          rr_d    = 1'b0;
        end else if (req1) begin
          state_d = GRANT1;
          rr_d    = 1'b1;
        end
      end
      GRANT0: begin
        s0_rdy = out_free;
        if (s0_rdy && bus.s0_tvalid && bus.s0_tlast) state_d = IDLE;
      end
      GRANT1: begin
        s1_rdy = out_free;
        if (s1_rdy && bus.s1_tvalid && bus.s1_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      rr_q      <= 1'b1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_tid_q   <= 1'b0;
      m_data_q  <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (acc0 || acc1) begin
        m_valid_q <= 1'b1;
        m_data_q  <= acc1 ? bus.s1_tdata : bus.s0_tdata;
        m_last_q  <= acc1 ? bus.s1_tlast : bus.s0_tlast;
        m_tid_q   <= acc1;
      end else if (bus.m_tready) begin
        m_valid_q <= 1'b0;
      end
      if (acc0 && bus.s0_tlast) cnt0_q <= cnt0_q + CNT_W'(1);
      if (acc1 && bus.s1_tlast) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign bus.s0_tready = s0_rdy;
  assign bus.s1_tready = s1_rdy;
  assign bus.m_tdata   = m_data_q;
  assign bus.m_tvalid  = m_valid_q;
  assign bus.m_tlast   = m_last_q;
  assign bus.m_tid     = m_tid_q;
  assign pkt_cnt0      = cnt0_q;
  assign pkt_cnt1      = cnt1_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed bench for stream_packet_arbiter. Source queues hold {tlast, tdata}
// beats; a bus process presents them and records every output transfer with
// its cycle number, and the main sequence compares those records against
// hand-written expected beats and spacings.
module tb_stream_packet_arbiter;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [1:0]       src_en;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
  logic [1:0]       state_dbg;

  stream_packet_arbiter_if #(.DATA_W(DATA_W)) intf ();

  stream_packet_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .aclk      (clk),
    .aresetn   (aresetn),
    .bus       (intf),
    .src_en    (src_en),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0]   q0[$];
  logic [DATA_W:0]   q1[$];
  logic [DATA_W+1:0] mon_q[$];
  int                mon_c[$];
  int                cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_sources();
    intf.s0_tvalid = (q0.size() > 0);
    intf.s0_tdata  = (q0.size() > 0) ? q0[0][DATA_W-1:0] : '0;
    intf.s0_tlast  = (q0.size() > 0) ? q0[0][DATA_W] : 1'b0;
    intf.s1_tvalid = (q1.size() > 0);
    intf.s1_tdata  = (q1.size() > 0) ? q1[0][DATA_W-1:0] : '0;
    intf.s1_tlast  = (q1.size() > 0) ? q1[0][DATA_W] : 1'b0;
  endtask

  // Bus process: present source heads, and just before each rising edge
  // decide which transfers that edge performs.
  initial begin
    logic a0, a1;
    intf.s0_tvalid = 1'b0;
    intf.s0_tdata  = '0;
    intf.s0_tlast  = 1'b0;
    intf.s1_tvalid = 1'b0;
    intf.s1_tdata  = '0;
    intf.s1_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      #1 refresh_sources();
      #3;
      cyc++;
      a0 = intf.s0_tvalid && intf.s0_tready;
      a1 = intf.s1_tvalid && intf.s1_tready;
      if (aresetn && intf.m_tvalid && intf.m_tready) begin
        mon_q.push_back({intf.m_tid, intf.m_tlast, intf.m_tdata});
        mon_c.push_back(cyc);
      end
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      @(posedge clk);
      #1 refresh_sources();
    end
  end

  // driver tasks
  task automatic push0(input logic last, input logic [DATA_W-1:0] d);
    q0.push_back({last, d});
  endtask

  task automatic push1(input logic last, input logic [DATA_W-1:0] d);
    q1.push_back({last, d});
  endtask

  task automatic do_reset();
    aresetn     = 1'b0;
    intf.m_tready = 1'b1;
    src_en      = 2'b00;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    mon_q.delete();
    mon_c.delete();
  endtask

  task automatic wait_beats(input string tag, input int n);
    int budget;
    budget = 0;
    while (mon_q.size() < n && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    chk(tag, 128'(mon_q.size()), 128'(n));
  endtask

  // scoreboard pop: compares the next recorded output beat
  task automatic exp_beat(input string tag, input logic tid, input logic last,
                          input logic [DATA_W-1:0] data, output int c);
    logic [127:0] obs;
    if (mon_q.size() > 0) begin
      obs = 128'(mon_q.pop_front());
      c   = mon_c.pop_front();
    end else begin
      obs = 'x;
      c   = -1;
    end
    chk(tag, obs, 128'({tid, last, data}));
  endtask

  int c0, c1, c2, c3, c4, c5;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              stall;

  initial begin
    // reset state
    aresetn       = 1'b0;
    intf.m_tready = 1'b1;
    src_en        = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", 128'(intf.m_tvalid), 128'(0));
    chk("rst_m_tlast", 128'(intf.m_tlast), 128'(0));
    chk("rst_m_tid", 128'(intf.m_tid), 128'(0));
    chk("rst_m_tdata", 128'(intf.m_tdata), 128'(0));
    chk("rst_pkt_cnt0", 128'(pkt_cnt0), 128'(0));
    chk("rst_pkt_cnt1", 128'(pkt_cnt1), 128'(0));
    chk("rst_s0_tready", 128'(intf.s0_tready), 128'(0));
    chk("rst_s1_tready", 128'(intf.s1_tready), 128'(0));
    chk("rst_state", 128'(state_dbg), 128'(0));

    // both sources, 3-beat packets: source 0 first, one idle gap, source 1
    do_reset();
    src_en = 2'b11;
    push0(1'b0, 64'hA0); push0(1'b0, 64'hA1); push0(1'b1, 64'hA2);
    push1(1'b0, 64'hB0); push1(1'b0, 64'hB1); push1(1'b1, 64'hB2);
    wait_beats("026_count", 6);
    exp_beat("026_a0", 1'b0, 1'b0, 64'hA0, c0);
    exp_beat("026_a1", 1'b0, 1'b0, 64'hA1, c1);
    exp_beat("026_a2", 1'b0, 1'b1, 64'hA2, c2);
    exp_beat("026_b0", 1'b1, 1'b0, 64'hB0, c3);
    exp_beat("026_b1", 1'b1, 1'b0, 64'hB1, c4);
    exp_beat("026_b2", 1'b1, 1'b1, 64'hB2, c5);
    chk("026_gap01", 128'(c1 - c0), 128'(1));
    chk("026_gap12", 128'(c2 - c1), 128'(1));
    chk("026_gap23", 128'(c3 - c2), 128'(2));
    chk("026_gap45", 128'(c5 - c4), 128'(1));
    @(negedge clk);
    chk("026_cnt0", 128'(pkt_cnt0), 128'(1));
    chk("026_cnt1", 128'(pkt_cnt1), 128'(1));

    // four single-beat packets from source 0, two cycles apart
    do_reset();
    src_en = 2'b01;
    push0(1'b1, 64'hC0); push0(1'b1, 64'hC1); push0(1'b1, 64'hC2); push0(1'b1, 64'hC3);
    wait_beats("027_count", 4);
    exp_beat("027_p0", 1'b0, 1'b1, 64'hC0, c0);
    exp_beat("027_p1", 1'b0, 1'b1, 64'hC1, c1);
    exp_beat("027_p2", 1'b0, 1'b1, 64'hC2, c2);
    exp_beat("027_p3", 1'b0, 1'b1, 64'hC3, c3);
    chk("027_gap01", 128'(c1 - c0), 128'(2));
    chk("027_gap23", 128'(c3 - c2), 128'(2));
    @(negedge clk);
    chk("027_cnt0", 128'(pkt_cnt0), 128'(4));
    chk("027_cnt1", 128'(pkt_cnt1), 128'(0));

    // 8-beat packet from source 1 with m_tready 5 low / 5 high
    do_reset();
    src_en = 2'b10;
    for (int i = 0; i < 8; i++) push1(i == 7, 64'hD0 + 64'(i));
    stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall) begin
        chk("028_hold_valid", 128'(intf.m_tvalid), 128'(1));
        chk("028_hold_beat", 128'({intf.m_tlast, intf.m_tdata}), 128'({hold_last, hold_data}));
      end
      intf.m_tready = ((i / 5) % 2) == 1;
      stall     = intf.m_tvalid && !intf.m_tready;
      hold_data = intf.m_tdata;
      hold_last = intf.m_tlast;
    end
    intf.m_tready = 1'b1;
    wait_beats("028_count", 8);
    for (int i = 0; i < 8; i++) exp_beat("028_beat", 1'b1, i == 7, 64'hD0 + 64'(i), c0);
    chk("028_cnt1", 128'(pkt_cnt1), 128'(1));

    // src_en[0] dropped mid-packet: packet completes, source 1 next,
    // source 0 held off until re-enabled
    do_reset();
    src_en = 2'b11;
    push0(1'b0, 64'hE0); push0(1'b0, 64'hE1); push0(1'b0, 64'hE2); push0(1'b1, 64'hE3);
    push1(1'b0, 64'hF0); push1(1'b1, 64'hF1);
    wait_beats("029_first", 1);
    src_en = 2'b10;
    push0(1'b0, 64'h70); push0(1'b1, 64'h71);
    wait_beats("029_count6", 6);
    repeat (10) @(negedge clk);
    chk("029_held_count", 128'(mon_q.size()), 128'(6));
    chk("029_held_state", 128'(state_dbg), 128'(0));
    chk("029_held_s0_tready", 128'(intf.s0_tready), 128'(0));
    src_en = 2'b11;
    wait_beats("029_count8", 8);
    exp_beat("029_e0", 1'b0, 1'b0, 64'hE0, c0);
    exp_beat("029_e1", 1'b0, 1'b0, 64'hE1, c0);
    exp_beat("029_e2", 1'b0, 1'b0, 64'hE2, c0);
    exp_beat("029_e3", 1'b0, 1'b1, 64'hE3, c0);
    exp_beat("029_f0", 1'b1, 1'b0, 64'hF0, c0);
    exp_beat("029_f1", 1'b1, 1'b1, 64'hF1, c0);
    exp_beat("029_g0", 1'b0, 1'b0, 64'h70, c0);
    exp_beat("029_g1", 1'b0, 1'b1, 64'h71, c0);

    // one-cycle reset in the middle of a 6-beat packet
    do_reset();
    src_en = 2'b11;
    push1(1'b1, 64'h80);
    wait_beats("030_single", 1);
    chk("030_cnt1_pre", 128'(pkt_cnt1), 128'(1));
    for (int i = 0; i < 6; i++) push0(i == 5, 64'h90 + 64'(i));
    wait_beats("030_pre", 3);
    aresetn = 1'b0;
    q0.delete();
    @(negedge clk);
    aresetn = 1'b1;
    chk("030_m_tvalid", 128'(intf.m_tvalid), 128'(0));
    chk("030_m_tdata", 128'(intf.m_tdata), 128'(0));
    chk("030_cnt0", 128'(pkt_cnt0), 128'(0));
    chk("030_cnt1", 128'(pkt_cnt1), 128'(0));
    chk("030_state", 128'(state_dbg), 128'(0));
    repeat (5) @(negedge clk);
    chk("030_no_more", 128'(mon_q.size()), 128'(3));
    push0(1'b0, 64'h60); push0(1'b1, 64'h61);
    wait_beats("030_post", 5);
    exp_beat("030_s", 1'b1, 1'b1, 64'h80, c0);
    exp_beat("030_p0", 1'b0, 1'b0, 64'h90, c0);
    exp_beat("030_p1", 1'b0, 1'b0, 64'h91, c0);
    exp_beat("030_n0", 1'b0, 1'b0, 64'h60, c0);
    exp_beat("030_n1", 1'b0, 1'b1, 64'h61, c0);
    chk("030_cnt0_post", 128'(pkt_cnt0), 128'(1));

    // counter wrap: 17 packets into a 4-bit counter
    do_reset();
    src_en = 2'b10;
    for (int i = 0; i < 17; i++) push1(1'b1, 64'(i));
    wait_beats("031_count", 17);
    chk("031_cnt1_wrap", 128'(pkt_cnt1), 128'(1));
    chk("031_cnt0", 128'(pkt_cnt0), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
